acc_c_arbiter: RTL and testbench

// Shares one accelerator C-bus port (request Q / response P, valid/ready on both) among

---
 rtl/acc_c_arbiter.sv | 205 ++++++++++++++++++++
 tb/tb_acc_c_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_c_arbiter.sv
// Round-robin sharing of one accelerator C-bus port among NumReq requesters.
// Q and P channels pass through combinationally; only grant lock, RR pointer and counters are stored.
module acc_c_arbiter #(
    parameter int NumReq         = 2,
    parameter int DataWidth      = 32,
    parameter int AddrWidth      = 5,
    parameter int IdWidth        = 4,
    parameter int MaxOutstanding = 4,
    localparam int IdxW          = $clog2(NumReq),
    localparam int OutIdW        = IdWidth + IdxW
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NumReq*AddrWidth-1:0]   slv_q_addr_i,
    input  logic [NumReq*32-1:0]          slv_q_data_op_i,
    input  logic [NumReq*3*DataWidth-1:0] slv_q_data_arg_i,
    input  logic [NumReq*IdWidth-1:0]     slv_q_id_i,
    input  logic [NumReq-1:0]             slv_q_valid_i,
    output logic [NumReq-1:0]             slv_q_ready_o,
    output logic [2*DataWidth-1:0]        slv_p_data_o,
    output logic                          slv_p_dual_wb_o,
    output logic [IdWidth-1:0]            slv_p_id_o,
    output logic [4:0]                    slv_p_rd_o,
    output logic                          slv_p_error_o,
    output logic [NumReq-1:0]             slv_p_valid_o,
    input  logic [NumReq-1:0]             slv_p_ready_i,
    output logic [AddrWidth-1:0]          mst_q_addr_o,
    output logic [31:0]                   mst_q_data_op_o,
    output logic [DataWidth-1:0]          mst_q_data_arga_o,
    output logic [DataWidth-1:0]          mst_q_data_argb_o,
    output logic [DataWidth-1:0]          mst_q_data_argc_o,
    output logic [OutIdW-1:0]             mst_q_id_o,
    output logic                          mst_q_valid_o,
    input  logic                          mst_q_ready_i,
    input  logic [DataWidth-1:0]          mst_p_data0_i,
    input  logic [DataWidth-1:0]          mst_p_data1_i,
    input  logic                          mst_p_dual_wb_i,
    input  logic [OutIdW-1:0]             mst_p_id_i,
    input  logic [4:0]                    mst_p_rd_i,
    input  logic                          mst_p_error_i,
    input  logic                          mst_p_valid_i,
    output logic                          mst_p_ready_o
);

    localparam int CntW = $clog2(MaxOutstanding + 1);
    typedef logic [CntW-1:0] cnt_t;
    typedef enum logic {StIdle, StLocked} state_e;

    state_e          state_q, state_d;
    logic [IdxW-1:0] grant_q, grant_d;
    logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
    cnt_t            cnt_q [NumReq];
    cnt_t            cnt_d [NumReq];

    logic [NumReq-1:0] elig;
    logic [IdxW-1:0]   rr_sel;
    logic [IdxW-1:0]   gnt;
    logic              q_valid;
    logic              q_hs;
    logic [IdxW-1:0]   p_idx;
    logic              p_idx_ok;
    logic              p_hs;

    always_comb begin
        for (int k = 0; k < NumReq; k++) begin
            elig[k] = slv_q_valid_i[k] && (cnt_q[k] < cnt_t'(MaxOutstanding));
        end
    end

    // Walk offsets from the far end so the nearest eligible index after rr_ptr wins.
    always_comb begin
        rr_sel = rr_ptr_q;
        for (int o = NumReq - 1; o >= 0; o--) begin
            for (int k = 0; k < NumReq; k++) begin
                if ((((int'(rr_ptr_q) + o) % NumReq) == k) && elig[k]) begin
                    rr_sel = IdxW'(k);
                end
            end
        end
    end

    assign gnt     = (state_q == StLocked) ? grant_q : rr_sel;
    assign q_valid = rst_ni && ((state_q == StLocked) || (|elig));
    assign q_hs    = q_valid && mst_q_ready_i;

    always_comb begin
        mst_q_addr_o      = '0;
        mst_q_data_op_o   = '0;
        mst_q_data_arga_o = '0;
        mst_q_data_argb_o = '0;
        mst_q_data_argc_o = '0;
        mst_q_id_o        = '0;
        slv_q_ready_o     = '0;
        for (int k = 0; k < NumReq; k++) begin
            if (gnt == IdxW'(k)) begin
                mst_q_addr_o      = slv_q_addr_i[k*AddrWidth +: AddrWidth];
                mst_q_data_op_o   = slv_q_data_op_i[k*32 +: 32];
                mst_q_data_arga_o = slv_q_data_arg_i[k*3*DataWidth +: DataWidth];
                mst_q_data_argb_o = slv_q_data_arg_i[k*3*DataWidth + DataWidth +: DataWidth];
                mst_q_data_argc_o = slv_q_data_arg_i[k*3*DataWidth + 2*DataWidth +: DataWidth];
                mst_q_id_o        = {IdxW'(k), slv_q_id_i[k*IdWidth +: IdWidth]};
                slv_q_ready_o[k]  = q_valid && mst_q_ready_i;
            end
        end
    end

    assign mst_q_valid_o = q_valid;

    assign p_idx           = mst_p_id_i[OutIdW-1:IdWidth];
    assign p_idx_ok        = (32'(p_idx) < 32'(NumReq));
    assign slv_p_data_o    = {mst_p_data1_i, mst_p_data0_i};
    assign slv_p_dual_wb_o = mst_p_dual_wb_i;
    assign slv_p_id_o      = mst_p_id_i[IdWidth-1:0];
    assign slv_p_rd_o      = mst_p_rd_i;
    assign slv_p_error_o   = mst_p_error_i;

    // Out-of-range indices match no port and keep the default ready, so they are sunk.
    always_comb begin
        slv_p_valid_o = '0;
        mst_p_ready_o = rst_ni;
        for (int k = 0; k < NumReq; k++) begin
            if (p_idx == IdxW'(k)) begin
                slv_p_valid_o[k] = rst_ni && mst_p_valid_i;
                mst_p_ready_o    = rst_ni && slv_p_ready_i[k];
            end
        end
    end

    assign p_hs = mst_p_valid_i && mst_p_ready_o && p_idx_ok;

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        if (q_hs) begin
            state_d  = StIdle;
            rr_ptr_d = (gnt == IdxW'(NumReq - 1)) ? '0 : gnt + IdxW'(1);
        end else if (q_valid) begin
            state_d = StLocked;
            grant_d = gnt;
        end
    end

    // A same-cycle issue and retire on one requester cancel out.
    always_comb begin
        for (int k = 0; k < NumReq; k++) begin
            cnt_d[k] = cnt_q[k];
            if (q_hs && (gnt == IdxW'(k)) && !(p_hs && (p_idx == IdxW'(k)))) begin
                if (cnt_q[k] < cnt_t'(MaxOutstanding)) cnt_d[k] = cnt_q[k] + cnt_t'(1);
            end else if (p_hs && (p_idx == IdxW'(k)) && !(q_hs && (gnt == IdxW'(k)))) begin
                if (cnt_q[k] != '0) cnt_d[k] = cnt_q[k] - cnt_t'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            for (int k = 0; k < NumReq; k++) cnt_q[k] <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            for (int k = 0; k < NumReq; k++) cnt_q[k] <= cnt_d[k];
        end
    end

`ifndef SYNTHESIS
    localparam int QBusW = AddrWidth + 32 + 3*DataWidth + OutIdW;
    localparam int PBusW = 2*DataWidth + 1 + OutIdW + 5 + 1;
    logic             q_stall_q, p_stall_q;
    logic [QBusW-1:0] q_bus, q_prev_q;
    logic [PBusW-1:0] p_bus, p_prev_q;

    assign q_bus = {mst_q_addr_o, mst_q_data_op_o, mst_q_data_argc_o, mst_q_data_argb_o,
                    mst_q_data_arga_o, mst_q_id_o};
    assign p_bus = {mst_p_data1_i, mst_p_data0_i, mst_p_dual_wb_i, mst_p_id_i, mst_p_rd_i,
                    mst_p_error_i};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_stall_q <= 1'b0;
            p_stall_q <= 1'b0;
        end else begin
            q_stall_q <= mst_q_valid_o && !mst_q_ready_i;
            p_stall_q <= mst_p_valid_i && !mst_p_ready_o;
        end
    end

    always_ff @(posedge clk_i) begin
        q_prev_q <= q_bus;
        p_prev_q <= p_bus;
        if (rst_ni) begin
            if (q_stall_q) assert (mst_q_valid_o && (q_bus == q_prev_q));
            if (p_stall_q) assert (mst_p_valid_i && (p_bus == p_prev_q));
            assert ($onehot0(slv_q_ready_o));
            assert ($onehot0(slv_p_valid_o));
            if (mst_p_valid_i) assert (p_idx_ok);
        end
    end
`endif

endmodule

// File: tb/tb_acc_c_arbiter.sv
// Directed bench for acc_c_arbiter: a per-cycle reference model plus hand-computed spot checks.
module tb_acc_c_arbiter;

    localparam int NUM  = 2;
    localparam int MAXO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]   slv_q_addr;
    logic [63:0]  slv_q_op;
    logic [191:0] slv_q_arg;
    logic [7:0]   slv_q_id;
    logic [1:0]   req_valid;
    logic [1:0]   slv_q_ready;
    logic [63:0]  slv_p_data;
    logic         slv_p_dual;
    logic [3:0]   slv_p_id;
    logic [4:0]   slv_p_rd;
    logic         slv_p_err;
    logic [1:0]   slv_p_valid;
    logic [1:0]   slv_p_ready;
    logic [4:0]   mst_q_addr;
    logic [31:0]  mst_q_op;
    logic [31:0]  mst_q_arga, mst_q_argb, mst_q_argc;
    logic [4:0]   mst_q_id;
    logic         mst_q_valid;
    logic         mst_q_ready;
    logic [31:0]  mst_p_data0, mst_p_data1;
    logic         mst_p_dual;
    logic [4:0]   mst_p_id;
    logic [4:0]   mst_p_rd;
    logic         mst_p_err;
    logic         mst_p_valid;
    logic         mst_p_ready;

    int n_chk  = 0;
    int n_fail = 0;

    acc_c_arbiter dut (
        .clk_i(clk), .rst_ni(rst_n),
        .slv_q_addr_i(slv_q_addr), .slv_q_data_op_i(slv_q_op), .slv_q_data_arg_i(slv_q_arg),
        .slv_q_id_i(slv_q_id), .slv_q_valid_i(req_valid), .slv_q_ready_o(slv_q_ready),
        .slv_p_data_o(slv_p_data), .slv_p_dual_wb_o(slv_p_dual), .slv_p_id_o(slv_p_id),
        .slv_p_rd_o(slv_p_rd), .slv_p_error_o(slv_p_err), .slv_p_valid_o(slv_p_valid),
        .slv_p_ready_i(slv_p_ready),
        .mst_q_addr_o(mst_q_addr), .mst_q_data_op_o(mst_q_op), .mst_q_data_arga_o(mst_q_arga),
        .mst_q_data_argb_o(mst_q_argb), .mst_q_data_argc_o(mst_q_argc), .mst_q_id_o(mst_q_id),
        .mst_q_valid_o(mst_q_valid), .mst_q_ready_i(mst_q_ready),
        .mst_p_data0_i(mst_p_data0), .mst_p_data1_i(mst_p_data1), .mst_p_dual_wb_i(mst_p_dual),
        .mst_p_id_i(mst_p_id), .mst_p_rd_i(mst_p_rd), .mst_p_error_i(mst_p_err),
        .mst_p_valid_i(mst_p_valid), .mst_p_ready_o(mst_p_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input bit v, input logic [3:0] id, input logic [4:0] addr);
        req_valid[k]          = v;
        slv_q_id[k*4 +: 4]    = id;
        slv_q_addr[k*5 +: 5]  = addr;
        slv_q_op[k*32 +: 32]  = {16'hC0DE, 3'(k), addr, 4'h0, id};
        slv_q_arg[k*96 +: 96] = {24'hCCCCCC, 3'(k), addr, 24'hBBBBBB, 3'(k), addr,
                                 24'hAAAAAA, 3'(k), addr};
    endtask

    task automatic resp(input bit v, input logic [4:0] id, input logic [31:0] d);
        mst_p_valid = v;
        mst_p_id    = id;
        mst_p_data0 = d;
        mst_p_data1 = ~d;
        mst_p_rd    = d[4:0];
        mst_p_err   = d[0];
        mst_p_dual  = d[1];
    endtask

    // Reference model: outstanding counts, rotating priority start, held grant while stalled.
    int m_cnt [NUM];
    int m_rr, m_hold, m_g, m_k, m_pi;
    bit m_lock, m_any, m_ev, m_pr;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_rr = 0; m_lock = 0; m_hold = 0;
            for (int k = 0; k < NUM; k++) m_cnt[k] = 0;
            chk("rst_mst_q_valid", mst_q_valid, 0);
            chk("rst_slv_q_ready", slv_q_ready, 0);
            chk("rst_slv_p_valid", slv_p_valid, 0);
        end else begin
            m_any = 0; m_g = 0;
            for (int o = 0; o < NUM; o++) begin
                m_k = (m_rr + o) % NUM;
                if (!m_any && req_valid[m_k] && m_cnt[m_k] < MAXO) begin
                    m_any = 1; m_g = m_k;
                end
            end
            if (m_lock) m_g = m_hold;
            m_ev = m_lock || m_any;
            chk("m_q_valid", mst_q_valid, m_ev);
            chk("m_q_ready", slv_q_ready, (m_ev && mst_q_ready) ? (1 << m_g) : 0);
            if (m_ev) begin
                chk("m_q_id", mst_q_id, {m_g[0], slv_q_id[m_g*4 +: 4]});
                chk("m_q_addr", mst_q_addr, slv_q_addr[m_g*5 +: 5]);
                chk("m_q_op", mst_q_op, slv_q_op[m_g*32 +: 32]);
                chk("m_q_args", {mst_q_argc, mst_q_argb, mst_q_arga}, slv_q_arg[m_g*96 +: 96]);
            end
            m_pi = int'(mst_p_id[4]);
            m_pr = slv_p_ready[m_pi];
            chk("m_p_valid", slv_p_valid, mst_p_valid ? (1 << m_pi) : 0);
            chk("m_p_ready", mst_p_ready, m_pr);
            chk("m_p_bcast", {slv_p_data, slv_p_dual, slv_p_id, slv_p_rd, slv_p_err},
                {mst_p_data1, mst_p_data0, mst_p_dual, mst_p_id[3:0], mst_p_rd, mst_p_err});
            if (m_ev && mst_q_ready) begin
                m_cnt[m_g]++;
                m_lock = 0;
                m_rr = (m_g + 1) % NUM;
            end else if (m_ev) begin
                m_lock = 1;
                m_hold = m_g;
            end
            if (mst_p_valid && m_pr && m_cnt[m_pi] > 0) m_cnt[m_pi]--;
        end
    end

    initial begin
        rst_n = 0; req_valid = '0; slv_q_addr = '0; slv_q_op = '0; slv_q_arg = '0; slv_q_id = '0;
        slv_p_ready = '0; mst_q_ready = 1;
        set_req(0, 1, 4'h3, 5'd10);
        set_req(1, 1, 4'h5, 5'd20);
        resp(1, 5'h03, 32'h1234_5678);
        #1;
        chk("rst_q_valid_gated", mst_q_valid, 0);
        chk("rst_q_ready_gated", slv_q_ready, 0);
        chk("rst_p_valid_gated", slv_p_valid, 0);
        tick(); tick();
        resp(0, 5'h00, 32'h0); slv_p_ready = 2'b11;
        tick(); tick();

        // alternating grants from index 0
        tick(); rst_n = 1; #1;
        chk("rr_first_id", mst_q_id, 5'h03);
        chk("rr_first_ready", slv_q_ready, 2'b01);
        for (int i = 1; i < 5; i++) begin
            tick(); #1;
            chk("rr_alt_id", mst_q_id, (i % 2) ? 5'h15 : 5'h03);
        end
        tick(); set_req(0, 0, 4'h3, 5'd10); set_req(1, 0, 4'h5, 5'd20);
        resp(1, 5'h03, 32'h0000_0011); #1;
        chk("idle_q_valid", mst_q_valid, 0);
        chk("p_route0_valid", slv_p_valid, 2'b01);
        tick(); resp(1, 5'h03, 32'h0000_0022);
        tick(); resp(1, 5'h03, 32'h0000_0033);
        tick(); resp(1, 5'h15, 32'h0000_0044); #1;
        chk("p_route1_valid", slv_p_valid, 2'b10);
        chk("p_route1_id", slv_p_id, 4'h5);
        tick(); resp(1, 5'h15, 32'h0000_0055);

        // stalled grant holds while a new requester appears
        tick(); resp(0, 5'h00, 32'h0);
        set_req(0, 1, 4'h2, 5'd9); mst_q_ready = 0; #1;
        chk("stall_valid", mst_q_valid, 1);
        chk("stall_ready", slv_q_ready, 2'b00);
        chk("stall_id", mst_q_id, 5'h02);
        tick(); set_req(1, 1, 4'h6, 5'd11); #1;
        chk("lock_id", mst_q_id, 5'h02);
        chk("lock_addr", mst_q_addr, 5'd9);
        tick(); #1;
        chk("lock_id2", mst_q_id, 5'h02);
        tick(); mst_q_ready = 1; #1;
        chk("lock_hs_ready", slv_q_ready, 2'b01);
        tick(); set_req(0, 0, 4'h2, 5'd9); #1;
        chk("after_lock_id", mst_q_id, 5'h16);
        chk("after_lock_ready", slv_q_ready, 2'b10);
        tick(); set_req(1, 0, 4'h6, 5'd11); resp(1, 5'h02, 32'h0000_0066); #1;
        chk("after_lock_idle", mst_q_valid, 0);
        tick(); resp(1, 5'h16, 32'h0000_0077);

        // outstanding limit on requester 0
        tick(); resp(0, 5'h00, 32'h0); set_req(0, 1, 4'h1, 5'd4); #1;
        chk("lim_issue", mst_q_valid, 1);
        for (int i = 1; i < 4; i++) begin
            tick(); #1;
            chk("lim_issue", mst_q_valid, 1);
        end
        tick(); #1;
        chk("lim_full_valid", mst_q_valid, 0);
        chk("lim_full_ready", slv_q_ready, 2'b00);
        tick(); resp(1, 5'h01, 32'h0000_0088); #1;
        chk("lim_free_same_cycle", mst_q_valid, 0);
        chk("lim_free_p_ready", mst_p_ready, 1);
        tick(); resp(0, 5'h00, 32'h0); #1;
        chk("lim_reissue_valid", mst_q_valid, 1);
        chk("lim_reissue_ready", slv_q_ready, 2'b01);
        tick(); set_req(0, 0, 4'h1, 5'd4); resp(1, 5'h01, 32'h0000_0099);
        tick(); tick(); tick();

        // response held while requester 1 is not ready
        tick(); resp(1, 5'h17, 32'hCAFE_0007); slv_p_ready = 2'b00; #1;
        chk("p_hold_valid", slv_p_valid, 2'b10);
        chk("p_hold_id", slv_p_id, 4'h7);
        chk("p_hold_ready", mst_p_ready, 0);
        tick(); #1;
        chk("p_hold_valid2", slv_p_valid, 2'b10);
        chk("p_hold_ready2", mst_p_ready, 0);
        tick(); slv_p_ready = 2'b10; #1;
        chk("p_release_ready", mst_p_ready, 1);

        // same-cycle issue and retire on requester 1
        tick(); resp(0, 5'h00, 32'h0); slv_p_ready = 2'b11; set_req(1, 1, 4'h8, 5'd20); #1;
        chk("sc_id", mst_q_id, 5'h18);
        tick();
        tick(); resp(1, 5'h18, 32'h0000_00AA); #1;
        chk("sc_both_q", mst_q_valid, 1);
        chk("sc_both_p", slv_p_valid, 2'b10);
        tick(); resp(0, 5'h00, 32'h0); #1;
        chk("sc_after1", mst_q_valid, 1);
        tick(); #1;
        chk("sc_after2", mst_q_valid, 1);
        tick(); #1;
        chk("sc_blocked", mst_q_valid, 0);

        // reset while locked with counts {3,1}
        tick(); set_req(1, 0, 4'h8, 5'd20); resp(1, 5'h18, 32'h0000_00BB);
        tick(); tick();
        tick(); resp(0, 5'h00, 32'h0); set_req(0, 1, 4'h4, 5'd1);
        tick(); tick();
        tick(); set_req(1, 1, 4'h9, 5'd2); mst_q_ready = 0; #1;
        chk("pre_rst_id", mst_q_id, 5'h19);
        chk("pre_rst_valid", mst_q_valid, 1);
        tick(); rst_n = 0; #1;
        chk("mid_rst_valid", mst_q_valid, 0);
        chk("mid_rst_ready", slv_q_ready, 2'b00);
        tick(); tick();
        rst_n = 1; mst_q_ready = 1; #1;
        chk("post_rst_id", mst_q_id, 5'h04);
        chk("post_rst_ready", slv_q_ready, 2'b01);
        tick(); set_req(1, 0, 4'h9, 5'd2); #1;
        chk("post_rst_cnt1", mst_q_valid, 1);
        tick(); #1;
        chk("post_rst_cnt2", mst_q_valid, 1);
        tick(); #1;
        chk("post_rst_cnt3", mst_q_valid, 1);
        tick(); #1;
        chk("post_rst_full", mst_q_valid, 0);
        tick(); set_req(0, 0, 4'h4, 5'd1);
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
